// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: host-side run controller for one QEA instance.
// It streams gate context into the QEA, seeds the state RAM with |0...0>,
// pulses start, waits for completion (with an optional timeout), and then
// streams every state word back out to the host.
module qea_host_sequencer #(
    parameter int                          PE_NUM_WIDTH            = 2,
    parameter int                          PE_NUM                  = 4,
    parameter int                          STATE_DATA_WIDTH        = 64,
    parameter int                          STATE_ADDR_WIDTH        = 16,
    parameter int                          GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int                          GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int                          MAX_QBIT_WIDTH          = 6,
    parameter logic [STATE_DATA_WIDTH-1:0] INIT_AMP                = 64'h40000000_00000000,
    parameter int                          RD_LAT                  = 1,
    parameter logic [31:0]                 TIMEOUT_CYC             = 32'd0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ins_num,
    input  logic                                   i_ctx_valid,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
    output logic                                   o_ctx_ready,
    output logic                                   o_ctx_en,
    output logic                                   o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]     o_ctx_data,
    output logic [PE_NUM-1:0]                      o_state_ena,
    output logic [PE_NUM-1:0]                      o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dina,
    output logic                                   o_qea_start,
    input  logic                                   i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
    output logic                                   o_rd_valid,
    output logic                                   o_rd_last,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_rd_data,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_err_cfg,
    output logic                                   o_err_timeout,
    output logic [31:0]                            o_exec_cycles
);

    localparam int SW   = PE_NUM * STATE_DATA_WIDTH;
    localparam int SAW  = STATE_ADDR_WIDTH;
    localparam int GCAW = GATE_CONTEXT_ADDR_WIDTH;

    // Basis state 0 holds amplitude 1.0 in the top lane of word 0.
    localparam logic [SW-1:0] INIT_WORD = {INIT_AMP, {(SW-STATE_DATA_WIDTH){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CTX,
        S_LOAD_STATE,
        S_START,
        S_RUN,
        S_READ,
        S_DONE,
        S_ERR
    } state_e;

    state_e                         state_q, state_d;
    logic [GCAW-1:0]                insLast_q;
    logic [SAW-1:0]                 lastIdx_q;
    logic [GCAW-1:0]                ctxCnt_q;
    logic [SAW-1:0]                 addr_q;
    logic                           ctxEn_q;
    logic [GCAW-1:0]                ctxAddr_q;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctxData_q;
    logic [31:0]                    execCycles_q;
    logic                           runFirst_q;
    logic                           issuedAll_q;
    logic                           errCfg_q;
    logic                           errTimeout_q;
    logic [RD_LAT-1:0]              vPipe_q;
    logic [RD_LAT-1:0]              lPipe_q;

    logic                           goSeen;
    logic                           cfgBad;
    logic [31:0]                    qbitExt;
    logic [31:0]                    shamt;
    logic [SAW-1:0]                 cfgLastIdx;
    logic                           ctxAccept;
    logic                           ctxLastAccept;
    logic [31:0]                    execNext;
    logic                           runComplete;
    logic                           runTimeout;
    logic                           readIssue;
    logic                           readIssueLast;

    // Validate the requested configuration and derive the last state-word index.
    always_comb begin
        qbitExt    = 32'(i_qbit_num);
        cfgBad     = (qbitExt < 32'(PE_NUM_WIDTH + 1)) ||
                     (qbitExt > 32'(PE_NUM_WIDTH + STATE_ADDR_WIDTH)) ||
                     (i_ins_num == '0);
        shamt      = 32'(PE_NUM_WIDTH + STATE_ADDR_WIDTH) - qbitExt;
        cfgLastIdx = {SAW{1'b1}} >> shamt;
    end

    // Per-cycle event decodes shared by the FSM and the datapath.
    always_comb begin
        goSeen        = ((state_q == S_IDLE) || (state_q == S_ERR)) && i_go;
        ctxAccept     = (state_q == S_LOAD_CTX) && i_ctx_valid;
        ctxLastAccept = ctxAccept && (ctxCnt_q == insLast_q);
        execNext      = execCycles_q + 32'd1;
        runComplete   = (state_q == S_RUN) && !runFirst_q && i_qea_complete;
        runTimeout    = (state_q == S_RUN) && !runComplete &&
                        (TIMEOUT_CYC != 32'd0) && (execNext == TIMEOUT_CYC);
        readIssue     = (state_q == S_READ) && !issuedAll_q;
        readIssueLast = readIssue && (addr_q == lastIdx_q);
    end

    // FSM state register; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic walking the run sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (i_go) begin
                    state_d = cfgBad ? S_ERR : S_LOAD_CTX;
                end
            end
            S_LOAD_CTX: begin
                if (ctxLastAccept) state_d = S_LOAD_STATE;
            end
            S_LOAD_STATE: begin
                if (addr_q == lastIdx_q) state_d = S_START;
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (runComplete)     state_d = S_READ;
                else if (runTimeout) state_d = S_ERR;
            end
            S_READ: begin
                if (lPipe_q[RD_LAT-1]) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: config latch, context write register, address and cycle counters, error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            insLast_q    <= '0;
            lastIdx_q    <= '0;
            ctxCnt_q     <= '0;
            addr_q       <= '0;
            ctxEn_q      <= 1'b0;
            ctxAddr_q    <= '0;
            ctxData_q    <= '0;
            execCycles_q <= '0;
            runFirst_q   <= 1'b0;
            issuedAll_q  <= 1'b0;
            errCfg_q     <= 1'b0;
            errTimeout_q <= 1'b0;
        end else begin
            ctxEn_q <= 1'b0;
            if (goSeen) begin
                errCfg_q     <= cfgBad;
                errTimeout_q <= 1'b0;
                ctxCnt_q     <= '0;
                addr_q       <= '0;
                if (!cfgBad) begin
                    insLast_q <= i_ins_num - GCAW'(1);
                    lastIdx_q <= cfgLastIdx;
                end
            end
            if (ctxAccept) begin
                ctxEn_q   <= 1'b1;
                ctxAddr_q <= ctxCnt_q;
                ctxData_q <= i_ctx_data;
                ctxCnt_q  <= ctxCnt_q + GCAW'(1);
            end
            if (state_q == S_LOAD_STATE) begin
                addr_q <= addr_q + SAW'(1);
            end
            if (state_q == S_START) begin
                execCycles_q <= '0;
                addr_q       <= '0;
                runFirst_q   <= 1'b1;
                issuedAll_q  <= 1'b0;
            end
            if (state_q == S_RUN) begin
                execCycles_q <= execNext;
                runFirst_q   <= 1'b0;
            end
            if (runTimeout) begin
                errTimeout_q <= 1'b1;
            end
            if (readIssue) begin
                addr_q <= addr_q + SAW'(1);
                if (addr_q == lastIdx_q) issuedAll_q <= 1'b1;
            end
        end
    end

    // Delay the read-issue strobe and its last marker to line up with RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vPipe_q <= '0;
            lPipe_q <= '0;
        end else begin
            vPipe_q[0] <= readIssue;
            lPipe_q[0] <= readIssueLast;
            for (int i = 1; i < RD_LAT; i++) begin
                vPipe_q[i] <= vPipe_q[i-1];
                lPipe_q[i] <= lPipe_q[i-1];
            end
        end
    end

    // Output decode from the current state and counters.
    always_comb begin
        o_ctx_ready   = (state_q == S_LOAD_CTX);
        o_qea_start   = (state_q == S_START);
        o_done        = (state_q == S_DONE);
        o_busy        = (state_q == S_LOAD_CTX) || (state_q == S_LOAD_STATE) ||
                        (state_q == S_START) || (state_q == S_RUN) || (state_q == S_READ);
        o_state_ena   = '0;
        o_state_wea   = '0;
        o_state_addra = '0;
        o_state_dina  = '0;
        if (state_q == S_LOAD_STATE) begin
            o_state_ena   = '1;
            o_state_wea   = '1;
            o_state_addra = addr_q;
            if (addr_q == '0) o_state_dina = INIT_WORD;
        end else if (readIssue) begin
            o_state_ena   = '1;
            o_state_addra = addr_q;
        end
        o_rd_valid    = vPipe_q[RD_LAT-1];
        o_rd_last     = lPipe_q[RD_LAT-1];
        o_rd_data     = vPipe_q[RD_LAT-1] ? i_state_dout : '0;
    end

    assign o_ctx_en      = ctxEn_q;
    assign o_ctx_wea     = ctxEn_q;
    assign o_ctx_addr    = ctxAddr_q;
    assign o_ctx_data    = ctxData_q;
    assign o_err_cfg     = errCfg_q;
    assign o_err_timeout = errTimeout_q;
    assign o_exec_cycles = execCycles_q;

endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
- Host-side controller that drives one QEA instance through a full run without a testbench.
- Run order: load gate-context RAM from a valid/ready stream; initialise state RAM to |0…0⟩ in fixed-point; pulse start; wait for complete, with a timeout; sweep state RAM and stream the amplitudes out.
- Sits between a host/DMA stream interface and the QEA load, start and readout ports. Reports execution cycle count and error status.

Parameters:
- PE_NUM_WIDTH, 2, log2 of PE count.
- PE_NUM, 4, PE lanes per state word.
- STATE_DATA_WIDTH, 64, one complex amplitude (re:im, 32b each).
- STATE_ADDR_WIDTH, 16, state RAM word address width.
- GATE_CONTEXT_DATA_WIDTH, 64, context word width.
- GATE_CONTEXT_ADDR_WIDTH, 16, context address width.
- MAX_QBIT_WIDTH, 6, qubit-count field width.
- INIT_AMP, 64'h40000000_00000000, amplitude 1.0 (Q2.30 real, 0 imag) written at basis state 0.
- RD_LAT, 1, state RAM read latency in cycles.
- TIMEOUT_CYC, 32'd0, max RUN cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_go  in  1  run request, sampled in IDLE only
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on go
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, latched on go
- i_ctx_valid  in  1  context stream valid
- i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context stream data
- o_ctx_ready  out  1  context stream ready
- o_ctx_en, o_ctx_wea  out  1 each  QEA context write strobes
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  QEA context address
- o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH  QEA context data
- o_state_ena, o_state_wea  out  PE_NUM each  per-lane state RAM strobes
- o_state_addra  out  STATE_ADDR_WIDTH  state address
- o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state write data
- o_qea_start  out  1  QEA start pulse
- i_qea_complete  in  1  QEA done level
- i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state read data
- o_rd_valid, o_rd_last  out  1 each  readout stream flags
- o_rd_data  out  PE_NUM*STATE_DATA_WIDTH  readout data
- o_busy, o_done, o_err_cfg, o_err_timeout  out  1 each  status
- o_exec_cycles  out  32  cycles spent in RUN

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Reset mid-operation aborts immediately with no further QEA strobes.
- State words: N = 2^(qbit_num − PE_NUM_WIDTH).
- IDLE, on i_go:
  - If qbit_num < PE_NUM_WIDTH+1, or qbit_num − PE_NUM_WIDTH > STATE_ADDR_WIDTH, or ins_num == 0: go to ERR (o_err_cfg=1).
  - Otherwise latch the config, o_busy=1, go to LOAD_CTX.
  - i_go is ignored while busy.
- LOAD_CTX:
  - o_ctx_ready=1.
  - Each valid&ready cycle: o_ctx_en=o_ctx_wea=1 the next cycle, with addr k and that data; k runs 0..ins_num−1.
  - Valid low gives no write and the address holds.
  - After word ins_num−1 is accepted: ready drops the same cycle, go to LOAD_STATE.
- LOAD_STATE:
  - One write per cycle, ena=wea=all-ones, addr 0..N−1.
  - Word 0 carries INIT_AMP in lane PE_NUM−1 (top bits), zeros in other lanes; all other words are zero.
  - After word N−1: go to START.
- START: o_qea_start=1 for exactly one cycle; o_exec_cycles cleared. Then go to RUN.
- RUN:
  - o_exec_cycles increments each cycle.
  - i_qea_complete is masked on the first RUN cycle, which tolerates a stale level.
  - When complete is seen afterwards: counter frozen, go to READ.
  - If TIMEOUT_CYC≠0 and the count reaches TIMEOUT_CYC: go to ERR (o_err_timeout=1).
- READ:
  - Issue ena=all-ones, wea=0, addr 0..N−1, one per cycle.
  - o_rd_valid is the issue strobe delayed RD_LAT cycles, with o_rd_data=i_state_dout.
  - o_rd_last accompanies the data for addr N−1.
  - No backpressure.
  - After the last data is emitted: go to DONE.
- DONE: o_done=1 for one cycle, o_busy=0, go to IDLE. o_exec_cycles holds until the next START.
- ERR: error flag sticky, o_busy=0, all QEA strobes 0. The next i_go clears the flags and re-evaluates the config.
- Address counters are STATE_ADDR_WIDTH wide. For N = 2^STATE_ADDR_WIDTH the terminal test uses the last-index compare, not counter wrap.

Test Plan:
- Full run, qbit=13, ins=181, continuous valid:
  - 181 context writes, addr 0..180.
  - 2048 state writes; addr 0 dina = {INIT_AMP, 0, 0, 0}.
  - One start pulse.
  - QEA model asserts complete 500 cycles after start → o_exec_cycles=500±1 (checked exactly against the model), 2048 o_rd_valid, o_rd_last on the 2048th, o_done one cycle.
- Context stream with valid toggling every other cycle, ins=8 → addresses 0..7 written in order with no gaps or duplicates; the data matches the stream.
- qbit=1 → o_err_cfg=1 next cycle, no QEA strobes. A subsequent valid go with qbit=3, ins=1 completes, with 2 state words written and read.
- TIMEOUT_CYC=100, complete never asserted → o_err_timeout=1 at RUN count 100, o_busy=0, no readout.
- Complete held high before start → the masked first RUN cycle is followed by exit on cycle 2, o_exec_cycles=2.
- rst asserted during LOAD_STATE at addr 37 → all outputs 0 asynchronously; after release the FSM is in IDLE, and a new go restarts context load at addr 0.
